// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-addressed load/store controller for port A of the 32-bit block RAM.
// Define MEM_CTRL_SUBWORD_EN to build byte/half support; without it only aligned word accesses succeed.
module mem_ctrl #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   output logic              mem_we,
   input  logic [31:0]       mem_dout
);

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR, DONE} state_t;

   state_t state;
   state_t state_next;
   logic   op_we;
   logic   bad;
   logic   unused_bits;

`ifdef MEM_CTRL_SUBWORD_EN
   logic [1:0]  op_size;
   logic        op_sext;
   logic [1:0]  op_lane;
   logic [15:0] op_wdata;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_val;
   logic [31:0] merge_val;

   assign bad = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);
   assign unused_bits = ^addr[31:ADDR_W+2];

   // Lane extraction for loads and lane replacement for read-modify-write stores.
   always_comb begin
      rd_byte   = mem_dout[7:0];
      merge_val = mem_dout;
      load_val  = mem_dout;
      case (op_lane)
         2'd0: begin rd_byte = mem_dout[7:0];   merge_val[7:0]   = op_wdata[7:0]; end
         2'd1: begin rd_byte = mem_dout[15:8];  merge_val[15:8]  = op_wdata[7:0]; end
         2'd2: begin rd_byte = mem_dout[23:16]; merge_val[23:16] = op_wdata[7:0]; end
         default: begin rd_byte = mem_dout[31:24]; merge_val[31:24] = op_wdata[7:0]; end
      endcase
      rd_half = op_lane[1] ? mem_dout[31:16] : mem_dout[15:0];
      if (op_size == 2'b01) begin
         merge_val = op_lane[1] ? {op_wdata, mem_dout[15:0]} : {mem_dout[31:16], op_wdata};
      end
      case (op_size)
         2'b00:   load_val = {{24{op_sext & rd_byte[7]}}, rd_byte};
         2'b01:   load_val = {{16{op_sext & rd_half[15]}}, rd_half};
         default: load_val = mem_dout;
      endcase
   end
`else
   assign bad = (size != 2'b10) || (addr[1:0] != 2'b00);
   assign unused_bits = ^{addr[31:ADDR_W+2], sext};
`endif

   assign ready  = (state == DONE);
   assign busy   = (state != IDLE);
   assign mem_we = (state == WR);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Only full-word stores skip the read; everything rejected goes straight to DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (bad)                      state_next = DONE;
               else if (we && size == 2'b10) state_next = WR;
               else                          state_next = RD_WAIT;
            end
         end
         RD_WAIT: state_next = RD_DATA;
         RD_DATA: state_next = op_we ? WR : DONE;
         WR:      state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request capture on accept; RAM data consumed only in RD_DATA.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata    <= '0;
         mem_addr <= '0;
         mem_din  <= '0;
         err      <= 1'b0;
         op_we    <= 1'b0;
`ifdef MEM_CTRL_SUBWORD_EN
         op_size  <= '0;
         op_sext  <= 1'b0;
         op_lane  <= '0;
         op_wdata <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  op_we    <= we;
                  err      <= bad;
                  mem_addr <= addr[ADDR_W+1:2];
`ifdef MEM_CTRL_SUBWORD_EN
                  op_size  <= size;
                  op_sext  <= sext;
                  op_lane  <= addr[1:0];
                  op_wdata <= wdata[15:0];
`endif
                  if (!bad && we && size == 2'b10) mem_din <= wdata;
               end
            end
            RD_DATA: begin
`ifdef MEM_CTRL_SUBWORD_EN
               if (op_we) mem_din <= merge_val;
               else       rdata   <= load_val;
`else
               rdata <= mem_dout;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl with a behavioural RAM and reference model.
// Expectations follow MEM_CTRL_SUBWORD_EN the same way the design build does.
module tb_mem_ctrl;

   localparam int ADDR_W = 11;
`ifdef MEM_CTRL_SUBWORD_EN
   localparam bit SUBWORD = 1'b1;
`else
   localparam bit SUBWORD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              req;
   logic              we;
   logic [1:0]        size;
   logic              sext;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              ready;
   logic              err;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic              mem_we;
   logic [31:0]       mem_dout;

   int vectors     = 0;
   int miscompares = 0;
   int total_writes = 0;

   logic [31:0] ram     [0:(1<<ADDR_W)-1];
   logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
   logic [31:0] ref_rdata;

   mem_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
      .busy(busy), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Block RAM port A: one-cycle synchronous read, read-before-write.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   always @(negedge clk) if (mem_we) total_writes++;

   // Reference model: what an access should do, from byte-lane arithmetic on a word array.
   task automatic model_access(input logic w, input logic [1:0] sz, input logic sx,
                               input logic [31:0] a, input logic [31:0] wd,
                               output logic e_err, output int e_lat, output logic [31:0] e_word);
      int unsigned idx;
      int unsigned lane;
      logic [31:0] old;
      logic [31:0] mask;
      logic [31:0] field;
      logic        ok;
      idx   = (a / 4) % (1 << ADDR_W);
      lane  = a % 4;
      old   = ref_mem[idx];
      e_word = old;
      mask  = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
      if (sz == 2'd2)      ok = (lane == 0);
      else if (sz == 2'd1) ok = SUBWORD && (lane % 2 == 0);
      else                 ok = SUBWORD && (sz == 2'd0);
      e_err = !ok;
      e_lat = 1;
      if (ok && sz == 2'd2) begin
         if (w) begin e_word = wd; e_lat = 2; end
         else begin ref_rdata = old; e_lat = 3; end
      end else if (ok) begin
         field = (old >> (8 * lane)) & mask;
         if (w) begin
            e_word = (old & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
            e_lat  = 4;
         end else begin
            ref_rdata = (sx && field > (mask >> 1)) ? field - (mask + 1) : field;
            e_lat     = 3;
         end
      end
      ref_mem[idx] = e_word;
   endtask

   // Drives one request starting in an IDLE cycle and watches it until ready (bounded).
   task automatic apply_stimulus(input logic w, input logic [1:0] sz, input logic sx,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output int lat, output logic [31:0] got_rdata, output logic got_err,
                                 output int wcnt, output logic [ADDR_W-1:0] waddr, output logic [31:0] wdin);
      @(negedge clk);
      req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
      lat = -1; got_rdata = '0; got_err = 1'b0; wcnt = 0; waddr = '0; wdin = '0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) begin
            req = 1'b0; we = $urandom; size = $urandom; sext = $urandom;
            addr = $urandom; wdata = $urandom;
         end
         if (mem_we) begin wcnt++; waddr = mem_addr; wdin = mem_din; end
         if (ready) begin lat = n; got_rdata = rdata; got_err = err; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({rdata, mem_addr, mem_din} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_regs: got rdata=%h mem_addr=%h mem_din=%h required all 0", rdata, mem_addr, mem_din);
      end
      vectors++;
      if ({ready, err, busy, mem_we} !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got ready/err/busy/we=%b required 0000", {ready, err, busy, mem_we});
      end
      rst = 1'b0;
      ref_rdata = '0;
   endtask

   task automatic test_word();
      int lat; int wcnt; logic [31:0] r; logic e; logic [ADDR_W-1:0] wa; logic [31:0] wd;
      logic e_err; int e_lat; logic [31:0] e_word;
      model_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, e_err, e_lat, e_word);
      apply_stimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, r, e, wcnt, wa, wd);
      vectors++;
      if (lat !== 2 || e !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL word_store_lat: got lat=%0d err=%b required lat=2 err=0", lat, e);
      end
      vectors++;
      if (wcnt !== 1 || wa !== 11'd4 || wd !== 32'hDEADBEEF) begin
         miscompares++;
         $display("[TB] FAIL word_store_write: got n=%0d addr=%h din=%h required n=1 addr=004 din=deadbeef", wcnt, wa, wd);
      end
      model_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_err, e_lat, e_word);
      apply_stimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, r, e, wcnt, wa, wd);
      vectors++;
      if (lat !== 3 || e !== 1'b0 || wcnt !== 0) begin
         miscompares++;
         $display("[TB] FAIL word_load_lat: got lat=%0d err=%b writes=%0d required lat=3 err=0 writes=0", lat, e, wcnt);
      end
      vectors++;
      if (r !== 32'hDEADBEEF) begin
         miscompares++;
         $display("[TB] FAIL word_load_data: got %h required deadbeef", r);
      end
   endtask

   task automatic test_subword();
      int lat; int wcnt; logic [31:0] r; logic e; logic [ADDR_W-1:0] wa; logic [31:0] wd;
      logic e_err; int e_lat; logic [31:0] e_word;
      logic [31:0] prev;
      model_access(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, e_err, e_lat, e_word);
      apply_stimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, lat, r, e, wcnt, wa, wd);
`ifdef MEM_CTRL_SUBWORD_EN
      model_access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, e_err, e_lat, e_word);
      apply_stimulus(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, lat, r, e, wcnt, wa, wd);
      vectors++;
      if (r !== 32'hFFFFFF88 || lat !== 3 || e !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL byte_load_sext: got %h lat=%0d err=%b required ffffff88 lat=3 err=0", r, lat, e);
      end
      model_access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, e_err, e_lat, e_word);
      apply_stimulus(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat, r, e, wcnt, wa, wd);
      vectors++;
      if (r !== 32'h00000088) begin
         miscompares++;
         $display("[TB] FAIL byte_load_zext: got %h required 00000088", r);
      end
      model_access(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, e_err, e_lat, e_word);
      apply_stimulus(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, lat, r, e, wcnt, wa, wd);
      vectors++;
      if (r !== 32'hFFFFAABB) begin
         miscompares++;
         $display("[TB] FAIL half_load_sext: got %h required ffffaabb", r);
      end
      model_access(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, e_err, e_lat, e_word);
      apply_stimulus(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, lat, r, e, wcnt, wa, wd);
      vectors++;
      if (lat !== 4 || wcnt !== 1 || wa !== 11'd4 || wd !== 32'h1234AABB) begin
         miscompares++;
         $display("[TB] FAIL half_store: got lat=%0d n=%0d addr=%h din=%h required lat=4 n=1 addr=004 din=1234aabb", lat, wcnt, wa, wd);
      end
      model_access(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, e_err, e_lat, e_word);
      apply_stimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, lat, r, e, wcnt, wa, wd);
      model_access(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF55, e_err, e_lat, e_word);
      apply_stimulus(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF55, lat, r, e, wcnt, wa, wd);
      vectors++;
      if (lat !== 4 || wcnt !== 1 || wd !== 32'h889955BB) begin
         miscompares++;
         $display("[TB] FAIL byte_store: got lat=%0d n=%0d din=%h required lat=4 n=1 din=889955bb", lat, wcnt, wd);
      end
`else
      prev = ref_rdata;
      model_access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, e_err, e_lat, e_word);
      apply_stimulus(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, lat, r, e, wcnt, wa, wd);
      vectors++;
      if (lat !== 1 || e !== 1'b1 || wcnt !== 0 || r !== prev) begin
         miscompares++;
         $display("[TB] FAIL byte_unsupported: got lat=%0d err=%b n=%0d rdata=%h required lat=1 err=1 n=0 rdata=%h", lat, e, wcnt, r, prev);
      end
`endif
   endtask

   task automatic test_misaligned();
      int lat; int wcnt; logic [31:0] r; logic e; logic [ADDR_W-1:0] wa; logic [31:0] wd;
      logic e_err; int e_lat; logic [31:0] e_word;
      logic [31:0] prev;
      prev = ref_rdata;
      model_access(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, e_err, e_lat, e_word);
      apply_stimulus(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, lat, r, e, wcnt, wa, wd);
      vectors++;
      if (lat !== 1 || e !== 1'b1 || wcnt !== 0 || r !== prev) begin
         miscompares++;
         $display("[TB] FAIL misaligned_word_load: got lat=%0d err=%b n=%0d rdata=%h required lat=1 err=1 n=0 rdata=%h", lat, e, wcnt, r, prev);
      end
      model_access(1'b1, 2'd1, 1'b0, 32'h13, 32'hCAFE, e_err, e_lat, e_word);
      apply_stimulus(1'b1, 2'd1, 1'b0, 32'h13, 32'hCAFE, lat, r, e, wcnt, wa, wd);
      vectors++;
      if (lat !== 1 || e !== 1'b1 || wcnt !== 0 || r !== prev) begin
         miscompares++;
         $display("[TB] FAIL misaligned_half_store: got lat=%0d err=%b n=%0d rdata=%h required lat=1 err=1 n=0 rdata=%h", lat, e, wcnt, r, prev);
      end
      model_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_err, e_lat, e_word);
      apply_stimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, r, e, wcnt, wa, wd);
      vectors++;
      if (lat !== 3 || e !== 1'b0 || r !== ref_rdata) begin
         miscompares++;
         $display("[TB] FAIL after_error_load: got lat=%0d err=%b rdata=%h required lat=3 err=0 rdata=%h", lat, e, r, ref_rdata);
      end
   endtask

   task automatic test_reset_mid();
      int lat; int wcnt; logic [31:0] r; logic e; logic [ADDR_W-1:0] wa; logic [31:0] wd;
      logic e_err; int e_lat; logic [31:0] e_word;
      int writes_before;
      writes_before = total_writes;
      @(negedge clk);
`ifdef MEM_CTRL_SUBWORD_EN
      req = 1'b1; we = 1'b1; size = 2'd1; sext = 1'b0; addr = 32'h12; wdata = $urandom;
`else
      req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h10; wdata = $urandom;
`endif
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_access_busy: got busy=%b ready=%b required busy=1 ready=0", busy, ready);
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({rdata, mem_addr, mem_din, ready, err, busy, mem_we} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_abort: got rdata=%h addr=%h din=%h flags=%b required all 0", rdata, mem_addr, mem_din, {ready, err, busy, mem_we});
      end
      rst = 1'b0;
      ref_rdata = '0;
      repeat (4) @(negedge clk);
      vectors++;
      if (total_writes !== writes_before || ram[4] !== ref_mem[4]) begin
         miscompares++;
         $display("[TB] FAIL reset_no_write: got writes=%0d word4=%h required writes=%0d word4=%h", total_writes, ram[4], writes_before, ref_mem[4]);
      end
      model_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_err, e_lat, e_word);
      apply_stimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, r, e, wcnt, wa, wd);
      vectors++;
      if (lat !== 3 || e !== 1'b0 || r !== ref_rdata) begin
         miscompares++;
         $display("[TB] FAIL after_reset_load: got lat=%0d err=%b rdata=%h required lat=3 err=0 rdata=%h", lat, e, r, ref_rdata);
      end
   endtask

   task automatic test_random();
      int lat; int wcnt; logic [31:0] r; logic e; logic [ADDR_W-1:0] wa; logic [31:0] wd;
      logic e_err; int e_lat; logic [31:0] e_word;
      logic w; logic [1:0] sz; logic sx; logic [31:0] a; logic [31:0] d;
      for (int i = 0; i < 76; i++) begin
         if (i < 16) begin
            w = 1'b1; sz = 2'd2; sx = 1'b0;
            a = ($urandom & 32'hFFFF_E000) | (i << 2);
         end else begin
            w = $urandom; sz = $urandom; sx = $urandom;
            a = ($urandom & 32'hFFFF_E000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         end
         d = $urandom;
         model_access(w, sz, sx, a, d, e_err, e_lat, e_word);
         apply_stimulus(w, sz, sx, a, d, lat, r, e, wcnt, wa, wd);
         vectors++;
         if (lat !== e_lat || e !== e_err || r !== ref_rdata) begin
            miscompares++;
            $display("[TB] FAIL random_%0d: we=%b size=%0d addr=%h got lat=%0d err=%b rdata=%h required lat=%0d err=%b rdata=%h",
                     i, w, sz, a, lat, e, r, e_lat, e_err, ref_rdata);
         end
         vectors++;
         if (wcnt !== ((w && !e_err) ? 1 : 0) ||
             (w && !e_err && (wa !== a[ADDR_W+1:2] || wd !== e_word))) begin
            miscompares++;
            $display("[TB] FAIL random_write_%0d: got n=%0d addr=%h din=%h required n=%0d addr=%h din=%h",
                     i, wcnt, wa, wd, (w && !e_err) ? 1 : 0, a[ADDR_W+1:2], e_word);
         end
      end
   endtask

   task automatic test_back_to_back();
      int ready_cyc [3];
      logic [31:0] got [3];
      logic [31:0] exp_r [3];
      int idle_cnt;
      int k;
      logic e_err; int e_lat; logic [31:0] e_word;
      for (int i = 0; i < 3; i++) begin
         model_access(1'b0, 2'd2, 1'b0, i * 4, 32'h0, e_err, e_lat, e_word);
         exp_r[i] = ref_rdata;
         ready_cyc[i] = -1;
         got[i] = '0;
      end
      idle_cnt = 0;
      k = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h0; wdata = $urandom;
      for (int n = 1; n <= 30 && k < 3; n++) begin
         @(negedge clk);
         if (!busy) idle_cnt++;
         if (ready) begin
            ready_cyc[k] = n;
            got[k] = rdata;
            k++;
            addr = k * 4;
            if (k == 3) req = 1'b0;
         end
      end
      req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (ready_cyc[i] !== 3 + 4 * i || got[i] !== exp_r[i]) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_%0d: got cycle=%0d rdata=%h required cycle=%0d rdata=%h",
                     i, ready_cyc[i], got[i], 3 + 4 * i, exp_r[i]);
         end
      end
      vectors++;
      if (idle_cnt !== 2) begin
         miscompares++;
         $display("[TB] FAIL back_to_back_idle: got %0d idle cycles required 2", idle_cnt);
      end
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0; addr = '0; wdata = '0;
      ref_rdata = '0;
      $display("[TB] starting mem_ctrl bench (subword=%0d)", SUBWORD);
      test_reset();
      test_word();
      test_subword();
      test_misaligned();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory access controller between the multi-cycle CPU datapath and port A of the 32-bit dual-port block-RAM `memory` (11-bit word address, single write-enable bit, 1-cycle synchronous read).
- Converts byte-addressed load/store requests (byte, half, word) into word accesses.
- Performs read-modify-write for sub-word stores and extracts/extends sub-word loads.
- Returns results with a one-cycle `ready` pulse.

Parameters:
- ADDR_W, 11, word-address width driven to the RAM; byte address bits [ADDR_W+1:2] are used and higher bits are ignored.

Ports:
- clk  in  1  system clock, also drives RAM clka
- rst  in  1  synchronous active-high reset
- req  in  1  access request, sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error)
- sext  in  1  load sign-extend (1) or zero-extend (0)
- addr  in  32  byte address
- wdata  in  32  store data; byte/half taken from bits [7:0]/[15:0]
- rdata  out  32  load result, registered
- ready  out  1  one-cycle pulse: access complete
- err  out  1  valid with ready: misaligned or unsupported access
- busy  out  1  state != IDLE
- mem_addr  out  ADDR_W  to RAM addra, registered
- mem_din  out  32  to RAM dina, registered
- mem_we  out  1  to RAM wea, high only in state WR
- mem_dout  in  32  from RAM douta

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- Reset: state IDLE; rdata, mem_addr and mem_din = 0; ready, err, mem_we and busy = 0. Reset mid-access aborts immediately, and no write is issued afterwards.
- Byte order is little-endian: byte lane = addr[1:0], lane 0 = bits [7:0]; half lane = addr[1], lane 0 = bits [15:0].
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- States: IDLE, RD_WAIT, RD_DATA, WR, DONE.
- IDLE, on req:
  - Latches we, size, sext, addr[1:0] and wdata; mem_addr <= addr[ADDR_W+1:2].
  - Misaligned or size=11 -> DONE with err=1; no RAM write; rdata unchanged.
  - Word store -> WR; mem_din <= wdata.
  - Load or sub-word store -> RD_WAIT.
- RD_WAIT: mem_addr held; the RAM samples the address. -> RD_DATA.
- RD_DATA: mem_dout is valid.
  - Load: rdata <= extracted lane, sign- or zero-extended per sext; word loads pass through. -> DONE.
  - Sub-word store: mem_din <= mem_dout with the selected lane replaced by the wdata low bits. -> WR.
- WR: mem_we=1 for exactly this cycle. -> DONE.
- DONE: ready=1, err as latched (0 on success). -> IDLE.
- Latency, with the request in cycle 0 (ready high in cycle N):
  - word store N=2
  - load N=3
  - sub-word store N=4
  - error N=1
- req outside IDLE (including DONE) is ignored. A req held high is re-accepted in the cycle after ready, so back-to-back accesses are spaced by one IDLE cycle.
- err is cleared on the next accept.
- mem_dout is ignored outside RD_DATA. mem_addr and mem_din change only on accept or in RD_DATA.

Optional Feature:
- Macro MEM_CTRL_SUBWORD_EN.
  - Defined: byte and half loads/stores are supported as above.
  - Undefined: size != 10 is treated as unsupported and takes the error path (err=1, ready in N=1, no RAM access). RD_DATA only handles word loads; no merge logic is built.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> first access: mem_we=1 for one cycle with mem_addr=4, mem_din=0xDEADBEEF, ready in cycle 2. Second access: rdata=0xDEADBEEF, ready in cycle 3, err=0.
- RAM word 4 = 0x8899AABB; byte load @0x13 with sext=1 -> rdata=0xFFFFFF88. Same with sext=0 -> 0x00000088. Half load @0x10 with sext=1 -> 0xFFFFAABB.
- RAM word 4 = 0x8899AABB; half store wdata=0x00001234 @0x12 -> single write of 0x1234AABB to addr 4, ready in cycle 4. Byte store 0x55 @0x11 -> 0x889955BB.
- Word load @0x11 and half store @0x13 -> each gives ready+err in cycle 1, mem_we never asserted, rdata unchanged. The following aligned request succeeds with err=0.
- rst asserted during RD_DATA of a half store -> next cycle: IDLE, mem_we=0, all outputs 0, RAM contents unchanged. A new req after rst deasserts is accepted normally.
- req held high for three word loads @0x0/0x4/0x8 -> ready pulses in cycles 3, 7 and 11; busy low exactly one cycle between accesses. Also a build without MEM_CTRL_SUBWORD_EN: a byte load gives err=1 with ready in cycle 1.
